// File: rtl/param_rr_arbiter.sv
// N-requester arbiter with fixed-priority or round-robin selection, bounded grant hold and registered grants.
// Optional ARB_GRANT_CNT_EN adds a saturating 16-bit count of new grant events on port grant_count.
module param_rr_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0]        grant_count
`endif
);

  // With unlimited hold the counter only needs to record that a grant is in progress.
  localparam int HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
  localparam int HOLD_W   = $clog2(HOLD_SAT + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT_V = HOLD_W'(HOLD_SAT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [ID_W-1:0]    id_n, win_id, start;
  logic [NUM_REQ-1:0] gnt_n, cand, rot;
  logic               win_found, new_grant, holder_req, others_req, hold_ok;
  int                 sum;

  // Candidates exclude the current holder, so the same search serves handover and re-grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cand      = (state == GRANT) ? (req & ~gnt) : req;
    start     = (RR_MODE != 0) ? ptr : '0;
    rot       = NUM_REQ'({cand, cand} >> start);
    win_found = 1'b0;
    win_id    = '0;
    sum       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && rot[i]) begin
        win_found = 1'b1;
        sum       = i + int'(start);
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win_id    = ID_W'(sum);
      end
    end
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    id_n       = gnt_id;
    hold_n     = hold_cnt;
    ptr_n      = ptr;
    new_grant  = 1'b0;
    holder_req = |(req & gnt);
    others_req = |(req & ~gnt);
    hold_ok    = (MAX_HOLD == 0) || (hold_cnt < HOLD_SAT_V) || !others_req;

    case (state)
      IDLE: new_grant = win_found;
      GRANT: begin
        if (req == '0) begin
          state_n = IDLE;
          gnt_n   = '0;
          id_n    = '0;
          hold_n  = '0;
        end else if (holder_req && hold_ok) begin
          if (hold_cnt < HOLD_SAT_V) hold_n = hold_cnt + HOLD_W'(1);
        end else begin
          // Holder dropped or hit the hold limit: another requester is guaranteed here.
          new_grant = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (new_grant) begin
      state_n = GRANT;
      gnt_n   = NUM_REQ'(1) << win_id;
      id_n    = win_id;
      hold_n  = HOLD_W'(1);
      if (RR_MODE != 0)
        ptr_n = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_valid <= (state_n == GRANT);
      gnt_id    <= id_n;
      hold_cnt  <= hold_n;
      ptr       <= ptr_n;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else if (new_grant && (count_q != 16'hFFFF))
      count_q <= count_q + 16'd1;
  end

  assign grant_count = count_q;
`endif

endmodule

// File: tb/tb_param_rr_arbiter.sv
// Bench for param_rr_arbiter: a round-robin (MAX_HOLD=2) and a fixed-priority (MAX_HOLD=0) instance
// share stimulus; a directed vector table is followed by random traffic checked against a queue-free model.
module tb_param_rr_arbiter;
  localparam int N = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;

  logic [N-1:0] gnt_a, gnt_b;
  logic         valid_a, valid_b;
  logic [2:0]   id_a, id_b;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0]  cnt_a, cnt_b;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  param_rr_arbiter #(.NUM_REQ(N), .RR_MODE(1), .MAX_HOLD(2)) dut_rr (
    .clock(clock), .reset(reset), .req(req),
    .gnt(gnt_a), .gnt_valid(valid_a), .gnt_id(id_a)
`ifdef ARB_GRANT_CNT_EN
    , .grant_count(cnt_a)
`endif
  );

  param_rr_arbiter #(.NUM_REQ(N), .RR_MODE(0), .MAX_HOLD(0)) dut_fx (
    .clock(clock), .reset(reset), .req(req),
    .gnt(gnt_b), .gnt_valid(valid_b), .gnt_id(id_b)
`ifdef ARB_GRANT_CNT_EN
    , .grant_count(cnt_b)
`endif
  );

  // Reference model: unit 0 = round-robin/hold 2, unit 1 = fixed/unlimited hold.
  int m_rr[2]  = '{1, 0};
  int m_max[2] = '{2, 0};
  int m_holder[2];
  int m_cnt[2];
  int m_ptr[2];
  int m_count[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int pick(input int c, input logic [N-1:0] r, input int excl);
    int s;
    s = (m_rr[c] != 0) ? m_ptr[c] : 0;
    for (int o = 0; o < N; o++) begin
      int k;
      k = (s + o) % N;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic model_grant(input int c, input int k);
    m_holder[c] = k;
    m_cnt[c]    = 1;
    if (m_rr[c] != 0) m_ptr[c] = (k + 1) % N;
    if (m_count[c] < 65535) m_count[c]++;
  endtask

  task automatic model_step(input int c, input logic rst, input logic [N-1:0] r);
    int h;
    h = m_holder[c];
    if (rst) begin
      m_holder[c] = -1; m_cnt[c] = 0; m_ptr[c] = 0; m_count[c] = 0;
    end else if (h < 0) begin
      if (r != 0) model_grant(c, pick(c, r, -1));
    end else if (r == 0) begin
      m_holder[c] = -1; m_cnt[c] = 0;
    end else if (r[h] && (m_max[c] == 0 || m_cnt[c] < m_max[c] || $countones(r) == 1)) begin
      if (m_max[c] > 0 && m_cnt[c] < m_max[c]) m_cnt[c]++;
    end else begin
      model_grant(c, pick(c, r, h));
    end
  endtask

  task automatic apply(input logic rst, input logic [N-1:0] r);
    reset = rst;
    req   = r;
    @(posedge clock);
    model_step(0, rst, r);
    model_step(1, rst, r);
    #1;
  endtask

  task automatic check_unit(input string tag, input int c, input logic exp_v, input int exp_id);
    logic [N-1:0] eg;
    logic [2:0]   ei;
    eg = exp_v ? (N'(1) << exp_id) : '0;
    ei = exp_v ? 3'(exp_id) : 3'd0;
    if (c == 0) begin
      check({tag, " rr gnt"},   32'(gnt_a),   32'(eg));
      check({tag, " rr valid"}, 32'(valid_a), 32'(exp_v));
      check({tag, " rr id"},    32'(id_a),    32'(ei));
    end else begin
      check({tag, " fx gnt"},   32'(gnt_b),   32'(eg));
      check({tag, " fx valid"}, 32'(valid_b), 32'(exp_v));
      check({tag, " fx id"},    32'(id_b),    32'(ei));
    end
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         va;
    int           ida;
    logic         vb;
    int           idb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [N-1:0] r,
                              input logic va, input int ida, input logic vb, input int idb);
    vec_t v;
    v.rst = rst; v.req = r; v.va = va; v.ida = ida; v.vb = vb; v.idb = idb;
    vecs.push_back(v);
  endfunction

  initial begin
    int rot_ids[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0};
    logic [N-1:0] r;

    // Reset held with every agent requesting.
    add(1, 5'b11111, 0, 0, 0, 0);
    add(1, 5'b11111, 0, 0, 0, 0);
    // Rotation: round-robin alternates every two cycles, fixed holds agent 0.
    foreach (rot_ids[i]) add(0, 5'b11111, 1, rot_ids[i], 1, 0);
    // Agent 0 drops; then hold limit forces rr handover while fixed keeps agent 1.
    add(0, 5'b10110, 1, 1, 1, 1);
    add(0, 5'b10110, 1, 1, 1, 1);
    add(0, 5'b10110, 1, 2, 1, 1);
    add(0, 5'b10110, 1, 2, 1, 1);
    add(0, 5'b10100, 1, 4, 1, 2);
    add(0, 5'b10100, 1, 4, 1, 2);
    // Lone holder is never preempted.
    for (int i = 0; i < 10; i++) add(0, 5'b00100, 1, 2, 1, 2);
    add(0, 5'b00000, 0, 0, 0, 0);
    // Grant agent 3 (rr pointer -> 4), then wrap to agent 0, re-grant 3, reset mid-grant.
    add(0, 5'b01000, 1, 3, 1, 3);
    add(0, 5'b00001, 1, 0, 1, 0);
    add(0, 5'b01000, 1, 3, 1, 3);
    add(1, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b11111, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].req);
      check_unit($sformatf("vec%0d", i), 0, vecs[i].va, vecs[i].ida);
      check_unit($sformatf("vec%0d", i), 1, vecs[i].vb, vecs[i].idb);
`ifdef ARB_GRANT_CNT_EN
      if (i == 1) begin
        check("reset rr count", 32'(cnt_a), 32'd0);
        check("reset fx count", 32'(cnt_b), 32'd0);
      end
      if (i == 12) begin
        check("rotation rr count", 32'(cnt_a), 32'd6);
        check("rotation fx count", 32'(cnt_b), 32'd1);
      end
`endif
    end

    // Random traffic against the model.
    r = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic rst;
      rst = ($urandom_range(0, 149) == 0);
      case ($urandom_range(0, 5))
        0:       r = '0;
        1:       r = N'(1) << $urandom_range(0, N - 1);
        2, 3:    r = r;
        default: r = N'($urandom);
      endcase
      apply(rst, r);
      for (int c = 0; c < 2; c++)
        check_unit($sformatf("rand%0d", cyc), c, m_holder[c] >= 0,
                   (m_holder[c] >= 0) ? m_holder[c] : 0);
`ifdef ARB_GRANT_CNT_EN
      check($sformatf("rand%0d rr count", cyc), 32'(cnt_a), 32'(m_count[0]));
      check($sformatf("rand%0d fx count", cyc), 32'(cnt_b), 32'(m_count[1]));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
